// File: rtl/tile_result_writer_pkg.sv
// Shared widths and FSM encoding for the tile result write-back path.
package tile_result_writer_pkg;

    localparam int ARRAYWIDTH          = 16;
    localparam int OUTPUT_BUF_DATASIZE = 32;
    localparam int LANE_W              = OUTPUT_BUF_DATASIZE;
    localparam int ROW_W               = LANE_W * ARRAYWIDTH;
    localparam int LANE_IDX_W          = $clog2(ARRAYWIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/tile_result_writer_row_fifo.sv
// Single-clock row FIFO; a pop in the same cycle frees the slot for a push when full.
module row_fifo
    import tile_result_writer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = ROW_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/tile_result_writer.sv
// Scatters 16-lane result rows into row-major result memory, skipping lanes/rows outside the matrix.
module tile_result_writer
    import tile_result_writer_pkg::*;
#(
    parameter int TILE_ROWS  = 16,
    parameter int M_ROWS     = 64,
    parameter int N_COLS     = 25,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] tile_row_base,
    input  logic [ADDR_W-1:0] tile_col_base,
    input  logic              in_valid,
    input  logic [ROW_W-1:0]  in_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [LANE_W-1:0] mem_wr_data,
    input  logic              mem_wr_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output state_e            dbg_state
);

    localparam int CNT_W = $clog2(TILE_ROWS + 1);
    localparam int EXT_W = ADDR_W + 1;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     row_base_q, row_base_d, col_base_q, col_base_d;
    logic [CNT_W-1:0]      rows_rcvd_q, rows_rcvd_d, row_idx_q, row_idx_d;
    logic [LANE_IDX_W-1:0] lane_ptr_q, lane_ptr_d;
    logic                  wr_en_q, wr_en_d, overflow_q, overflow_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [LANE_W-1:0]     wr_data_q, wr_data_d;

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ROW_W-1:0]      head_row, src_row;
    logic                  push_req, src_avail, load_en, consume, row_done;
    logic                  found, last_lane;
    logic [LANE_IDX_W-1:0] sel;
    logic [EXT_W-1:0]      r_ext, c_sel;
    logic [ARRAYWIDTH-1:0] cand;

    row_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ROW_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (in_data),
        .rd_data (head_row),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // With the FIFO empty the arriving row is drained directly, so the first
    // write leaves one cycle after the row arrives.
    always_comb begin
        push_req  = (state_q == ST_RUN) && in_valid && (rows_rcvd_q < CNT_W'(TILE_ROWS));
        src_row   = fifo_empty ? in_data : head_row;
        src_avail = !fifo_empty || push_req;
        load_en   = !wr_en_q || mem_wr_ready;
        r_ext     = {1'b0, row_base_q} + EXT_W'(row_idx_q);
        for (int k = 0; k < ARRAYWIDTH; k++) begin
            cand[k] = (r_ext < EXT_W'(M_ROWS))
                   && (({1'b0, col_base_q} + EXT_W'(k)) < EXT_W'(N_COLS))
                   && (k >= int'(lane_ptr_q));
        end
        found     = 1'b0;
        last_lane = 1'b1;
        sel       = '0;
        for (int k = 0; k < ARRAYWIDTH; k++) begin
            if (cand[k]) begin
                if (!found) begin
                    found = 1'b1;
                    sel   = LANE_IDX_W'(k);
                end else begin
                    last_lane = 1'b0;
                end
            end
        end
        c_sel = {1'b0, col_base_q} + EXT_W'(sel);
    end

    always_comb begin
        state_d     = state_q;
        row_base_d  = row_base_q;
        col_base_d  = col_base_q;
        rows_rcvd_d = rows_rcvd_q;
        row_idx_d   = row_idx_q;
        lane_ptr_d  = lane_ptr_q;
        wr_en_d     = wr_en_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        overflow_d  = overflow_q;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        consume     = 1'b0;
        row_done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    row_base_d  = tile_row_base;
                    col_base_d  = tile_col_base;
                    rows_rcvd_d = '0;
                    row_idx_d   = '0;
                    lane_ptr_d  = '0;
                end
            end
            ST_RUN: begin
                consume = src_avail && load_en;
                if (load_en) wr_en_d = 1'b0;
                if (consume) begin
                    if (found) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ADDR_W'(r_ext * EXT_W'(N_COLS) + c_sel);
                        wr_data_d = src_row[sel*LANE_W +: LANE_W];
                    end
                    row_done = !found || last_lane;
                    if (row_done) begin
                        lane_ptr_d = '0;
                        row_idx_d  = row_idx_q + 1'b1;
                    end else begin
                        lane_ptr_d = sel + 1'b1;
                    end
                end
                fifo_pop = row_done && !fifo_empty;
                if (push_req) begin
                    rows_rcvd_d = rows_rcvd_q + 1'b1;
                    if (fifo_full && !fifo_pop) overflow_d = 1'b1;
                    else if (!(fifo_empty && row_done)) fifo_push = 1'b1;
                end
                if ((rows_rcvd_q == CNT_W'(TILE_ROWS)) && fifo_empty && load_en) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            row_base_q  <= '0;
            col_base_q  <= '0;
            rows_rcvd_q <= '0;
            row_idx_q   <= '0;
            lane_ptr_q  <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_base_q  <= row_base_d;
            col_base_q  <= col_base_d;
            rows_rcvd_q <= rows_rcvd_d;
            row_idx_q   <= row_idx_d;
            lane_ptr_q  <= lane_ptr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            overflow_q  <= overflow_d;
        end
    end

    assign mem_wr_en   = wr_en_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign overflow    = overflow_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_tile_result_writer.sv
// Directed bench for tile_result_writer with a write scoreboard; a second instance covers row overflow.
module tb_tile_result_writer;
    import tile_result_writer_pkg::*;

    localparam int ADDR_W = 17;
    localparam int M_ROWS = 64;
    localparam int N_COLS = 25;

    logic              clk = 1'b0;
    logic              rst, start, o_start, in_valid, mem_wr_ready;
    logic [ADDR_W-1:0] tile_row_base, tile_col_base;
    logic [ROW_W-1:0]  in_data;

    logic              wr_en, busy, done, overflow;
    logic [ADDR_W-1:0] wr_addr;
    logic [LANE_W-1:0] wr_data;
    state_e            dbg_state;
    logic              o_wr_en, o_busy, o_done, o_overflow;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [LANE_W-1:0] o_wr_data;
    state_e            o_dbg_state;

    int                passed = 0, failed = 0, total = 0;
    int                wr_count = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic              use_ovf = 1'b0, rand_ready = 1'b0;
    logic [ADDR_W+LANE_W-1:0] exp_q[$];

    tile_result_writer u_dut (
        .clk(clk), .rst(rst), .start(start),
        .tile_row_base(tile_row_base), .tile_col_base(tile_col_base),
        .in_valid(in_valid), .in_data(in_data),
        .mem_wr_en(wr_en), .mem_wr_addr(wr_addr), .mem_wr_data(wr_data),
        .mem_wr_ready(mem_wr_ready), .busy(busy), .done(done),
        .overflow(overflow), .dbg_state(dbg_state)
    );

    tile_result_writer #(.TILE_ROWS(17)) u_ovf (
        .clk(clk), .rst(rst), .start(o_start),
        .tile_row_base(tile_row_base), .tile_col_base(tile_col_base),
        .in_valid(in_valid), .in_data(in_data),
        .mem_wr_en(o_wr_en), .mem_wr_addr(o_wr_addr), .mem_wr_data(o_wr_data),
        .mem_wr_ready(mem_wr_ready), .busy(o_busy), .done(o_done),
        .overflow(o_overflow), .dbg_state(o_dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LANE_W-1:0] lane_val(input int sc, input int i, input int k);
        return LANE_W'(sc * 4096 + i * 16 + k);
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) mem_wr_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic start_tile(input logic ovf, input int rb, input int cb);
        tile_row_base = ADDR_W'(rb);
        tile_col_base = ADDR_W'(cb);
        wr_count = 0;
        if (ovf) o_start = 1'b1;
        else start = 1'b1;
        tick();
        start = 1'b0;
        o_start = 1'b0;
    endtask

    task automatic send_rows(input int first, input int n, input int sc, input int rb, input int cb,
                             input int accept_lim);
        for (int i = first; i < first + n; i++) begin
            in_valid = 1'b1;
            for (int k = 0; k < ARRAYWIDTH; k++) begin
                in_data[k*LANE_W +: LANE_W] = lane_val(sc, i, k);
                if (i < accept_lim && (rb + i) < M_ROWS && (cb + k) < N_COLS)
                    exp_q.push_back({ADDR_W'((rb + i) * N_COLS + cb + k), lane_val(sc, i, k)});
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_writes, input int exp_last, input logic exp_ovf);
        int n = 0;
        while (!(use_ovf ? o_done : done) && n < 2000) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 64'(use_ovf ? o_done : done), 1);
        check({tag, "_busy_in_done"}, 64'(use_ovf ? o_busy : busy), 1);
        tick();
        check({tag, "_done_single"}, 64'(use_ovf ? o_done : done), 0);
        check({tag, "_busy_clear"}, 64'(use_ovf ? o_busy : busy), 0);
        check({tag, "_write_count"}, 64'(wr_count), 64'(exp_writes));
        check({tag, "_queue_empty"}, 64'(exp_q.size()), 0);
        check({tag, "_last_addr"}, 64'(last_addr), 64'(exp_last));
        check({tag, "_overflow"}, 64'(use_ovf ? o_overflow : overflow), 64'(exp_ovf));
    endtask

    // scoreboard: pops on every handshake, checks hold while stalled
    initial begin
        logic                     m_en, stall_prev;
        logic [ADDR_W+LANE_W-1:0] m_word, stall_word;
        stall_prev = 1'b0;
        stall_word = '0;
        forever begin
            @(negedge clk);
            m_en   = use_ovf ? o_wr_en : wr_en;
            m_word = use_ovf ? {o_wr_addr, o_wr_data} : {wr_addr, wr_data};
            if (stall_prev) begin
                check("hold_en", 64'(m_en), 1);
                check("hold_word", 64'(m_word), 64'(stall_word));
            end
            if (m_en && mem_wr_ready) begin
                if (exp_q.size() == 0) check("write_expected", 64'(exp_q.size() != 0), 1);
                else check("write", 64'(m_word), 64'(exp_q.pop_front()));
                wr_count++;
                last_addr = m_word[ADDR_W+LANE_W-1:LANE_W];
            end
            stall_prev = m_en && !mem_wr_ready && rst;
            stall_word = m_word;
        end
    end

    initial begin
        int n;
        rst = 1'b0; start = 1'b0; o_start = 1'b0; in_valid = 1'b0; in_data = '0;
        tile_row_base = '0; tile_col_base = '0; mem_wr_ready = 1'b1;
        repeat (3) tick();
        check("rst_wr_en", 64'(wr_en), 0);
        check("rst_wr_addr", 64'(wr_addr), 0);
        check("rst_wr_data", 64'(wr_data), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_overflow", 64'(overflow), 0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        rst = 1'b1;
        tick();

        // full tile at origin, with first-write latency
        start_tile(1'b0, 0, 0);
        check("s1_busy_after_start", 64'(busy), 1);
        check("s1_state_run", 64'(dbg_state), 64'(ST_RUN));
        send_rows(0, 1, 1, 0, 0, 16);
        check("s1_first_wr_en", 64'(wr_en), 1);
        check("s1_first_wr_addr", 64'(wr_addr), 0);
        send_rows(1, 15, 1, 0, 0, 16);
        wait_done("s1", 256, 390, 1'b0);

        // right edge: columns 16..24 only
        start_tile(1'b0, 48, 16);
        send_rows(0, 16, 2, 48, 16, 16);
        wait_done("s2", 144, 1599, 1'b0);

        // bottom edge: rows 8..15 fall outside
        start_tile(1'b0, 56, 0);
        send_rows(0, 16, 3, 56, 0, 16);
        wait_done("s3", 128, 1590, 1'b0);

        // random backpressure reproduces the origin tile
        rand_ready = 1'b1;
        start_tile(1'b0, 0, 0);
        send_rows(0, 16, 1, 0, 0, 16);
        wait_done("s4", 256, 390, 1'b0);
        rand_ready = 1'b0;
        mem_wr_ready = 1'b1;

        // overflow on the 17th row while memory stalls
        use_ovf = 1'b1;
        check("s5_idle_rows_ignored", 64'(o_overflow), 0);
        check("s5_idle_state", 64'(o_dbg_state), 64'(ST_IDLE));
        mem_wr_ready = 1'b0;
        start_tile(1'b1, 0, 0);
        send_rows(0, 16, 5, 0, 0, 16);
        check("s5_no_overflow_at_16", 64'(o_overflow), 0);
        send_rows(16, 1, 5, 0, 0, 16);
        check("s5_overflow_at_17", 64'(o_overflow), 1);
        repeat (22) tick();
        check("s5_no_write_while_stalled", 64'(wr_count), 0);
        mem_wr_ready = 1'b1;
        wait_done("s5", 256, 390, 1'b1);
        use_ovf = 1'b0;

        // reset during row 5 drain, then a clean rerun
        start_tile(1'b0, 0, 0);
        send_rows(0, 16, 6, 0, 0, 16);
        n = 0;
        while (wr_addr !== ADDR_W'(5 * N_COLS + 3) && n < 300) begin
            tick();
            n++;
        end
        check("s6_reached_row5", 64'(wr_addr), 64'(5 * N_COLS + 3));
        rst = 1'b0;
        tick();
        check("s6_abort_wr_en", 64'(wr_en), 0);
        check("s6_abort_busy", 64'(busy), 0);
        check("s6_abort_fifo_empty", 64'(u_dut.fifo_empty), 1);
        exp_q.delete();
        rst = 1'b1;
        repeat (3) tick();
        check("s6_quiet_after_abort", 64'(wr_en), 0);
        start_tile(1'b0, 0, 0);
        send_rows(0, 16, 1, 0, 0, 16);
        wait_done("s6", 256, 390, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
